tristate_array_reader: RTL and testbench

Reads an unpacked array of 4-state `logic` words, such as the constant-driven `tri1` arrays our writer-side test modules produce, and converts it into a 2-state encoded stream. The output is one element per accepted transfer over a valid/ready handshake. It is the consuming end of our multi-driven net fixtures: it makes every 0/1/x/z bit observable as plain `bit` data, so downstream checkers never compare 4-state values directly. It also reports a running count of unknown (x or z) bits per scan.

---
 rtl/tsr_pkg.sv | 30 +++
 rtl/tsr_bit_encoder.sv | 19 +
 rtl/tristate_array_reader.sv | 108 ++++++++++
 tb/tb_tristate_array_reader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tsr_pkg.sv
// Shared types for tristate_array_reader: FSM states, 2-bit code for one
// 4-state bit, and the classifier that maps 0/1/x/z onto that code.
package tsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        bit unk;
        bit val;
    } code_t;

    localparam code_t CODE_0 = 2'b00;
    localparam code_t CODE_1 = 2'b01;
    localparam code_t CODE_X = 2'b10;
    localparam code_t CODE_Z = 2'b11;

    // Case equality keeps x/z from leaking into the result. Whatever is
    // neither 0, 1 nor x must be z, so z never needs a literal compare.
    function automatic code_t encode_bit(logic b);
        if (b === 1'b0) return CODE_0;
        if (b === 1'b1) return CODE_1;
        if (b === 1'bx) return CODE_X;
        return CODE_Z;
    endfunction

endpackage

// File: rtl/tsr_bit_encoder.sv
// Combinational 4-state to 2-plane encoder for one W-bit word.
module tsr_bit_encoder
    import tsr_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] word,
    output bit   [W-1:0] out_val,
    output bit   [W-1:0] out_unk
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        code_t code;
        assign code       = encode_bit(word[i]);
        assign out_val[i] = code.val;
        assign out_unk[i] = code.unk;
    end

endmodule

// File: rtl/tristate_array_reader.sv
// Scans a 4-state array and streams each element as {unk,val} planes over
// valid/ready, counting unknown bits. TSR_SNAPSHOT_EN freezes src at start.
module tristate_array_reader
    import tsr_pkg::*;
#(
    parameter int ELEMS = 8,
    parameter int W     = 4,
    localparam int IW   = $clog2(ELEMS),
    localparam int CW   = $clog2(ELEMS*W+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  tri logic [W-1:0] src [0:ELEMS-1],
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output bit   [W-1:0]  out_val,
    output bit   [W-1:0]  out_unk,
    output logic          done,
    output logic [CW-1:0] unk_total
);

    state_t        state, next;
    logic          hs, last, load;
    logic [IW-1:0] sel;
    logic [W-1:0]  elem;
    bit   [W-1:0]  enc_val, enc_unk;

    assign hs   = out_valid && out_ready;
    assign last = (out_idx == IW'(ELEMS-1));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        next = state;
        load = 1'b0;
        sel  = out_idx + IW'(1);
        case (state)
            IDLE: if (start) begin
                next = SCAN;
                load = 1'b1;
                sel  = '0;
            end
            SCAN: if (hs) begin
                next = last ? DONE : SCAN;
                load = !last;
            end
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

`ifdef TSR_SNAPSHOT_EN
    logic [W-1:0] shadow [0:ELEMS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ELEMS; i++) shadow[i] <= '0;
        end else if (state == IDLE && start) begin
            shadow <= src;
        end
    end

    // Element 0 loads on the capture edge itself, so it comes straight from src.
    always_comb begin
        elem = shadow[sel];
        if (state == IDLE) elem = src[0];
    end
`else
    always_comb begin
        elem = src[sel];
    end
`endif

    tsr_bit_encoder #(.W(W)) u_enc (
        .word    (elem),
        .out_val (enc_val),
        .out_unk (enc_unk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_val   <= '0;
            out_unk   <= '0;
            unk_total <= '0;
        end else begin
            state <= next;
            if (state == IDLE && start)
                unk_total <= '0;
            else if (hs)
                unk_total <= unk_total + CW'($countones(out_unk));
            if (load) begin
                out_idx   <= sel;
                out_val   <= enc_val;
                out_unk   <= enc_unk;
                out_valid <= 1'b1;
            end else if (hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tristate_array_reader.sv
// Directed bench for tristate_array_reader: 4-element scans with backpressure,
// ignored starts, reset abort, live/snapshot sampling, and an 8-element scan.
module tb_tristate_array_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start4 = 1'b0, rdy4 = 1'b0;
    logic [3:0] src4 [0:3];
    logic       busy4, valid4, done4;
    logic [1:0] idx4;
    bit   [3:0] val4, unk4;
    logic [4:0] tot4;

    logic       start8 = 1'b0, rdy8 = 1'b0;
    logic [3:0] src8 [0:7];
    logic       busy8, valid8, done8;
    logic [2:0] idx8;
    bit   [3:0] val8, unk8;
    logic [5:0] tot8;

    tristate_array_reader #(.ELEMS(4), .W(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .src(src4), .busy(busy4),
        .out_valid(valid4), .out_ready(rdy4), .out_idx(idx4), .out_val(val4),
        .out_unk(unk4), .done(done4), .unk_total(tot4)
    );

    tristate_array_reader #(.ELEMS(8), .W(4)) u8 (
        .clk(clk), .rst(rst), .start(start8), .src(src8), .busy(busy8),
        .out_valid(valid8), .out_ready(rdy8), .out_idx(idx8), .out_val(val8),
        .out_unk(unk8), .done(done8), .unk_total(tot8)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit four_state;
    logic [3:0] ev [0:3];
    logic [3:0] eu [0:3];
    int et;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Fallback for 2-state simulators, where x/z literals collapse to 0/1.
    function automatic logic [7:0] ref_code(input logic [3:0] v);
        logic [3:0] a, u;
        a = '0;
        u = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] === 1'b1) a[i] = 1'b1;
            else if (v[i] !== 1'b0) begin
                u[i] = 1'b1;
                a[i] = (v[i] === 1'bz);
            end
        end
        return {u, a};
    endfunction

    task automatic expk(input int k, input logic [3:0] v, input logic [3:0] hv, input logic [3:0] hu);
        logic [7:0] c;
        c = ref_code(v);
        ev[k] = four_state ? hv : c[3:0];
        eu[k] = four_state ? hu : c[7:4];
    endtask

    task automatic set_tot;
        et = 0;
        for (int k = 0; k < 4; k++) et += $countones(eu[k]);
    endtask

    task automatic basic_src;
        src4[0] = 4'b0101;
        src4[1] = 4'b1x0z;
        src4[2] = 4'bzzzz;
        src4[3] = 4'bxxxx;
        expk(0, src4[0], 4'b0101, 4'b0000);
        expk(1, src4[1], 4'b1001, 4'b0101);
        expk(2, src4[2], 4'b1111, 4'b1111);
        expk(3, src4[3], 4'b0000, 4'b1111);
    endtask

    task automatic run4(input int stall_idx, input int stall_n, input bit poke,
                        input int chg_at, input logic [3:0] chg_val);
        start4 = 1'b1;
        rdy4   = 1'b1;
        step;
        start4 = 1'b0;
        chk("tot_clear", 32'(tot4), 32'(0));
        for (int k = 0; k < 4; k++) begin
            chk("valid", 32'(valid4), 32'(1));
            chk("idx", 32'(idx4), 32'(k));
            chk("val", 32'(val4), 32'(ev[k]));
            chk("unk", 32'(unk4), 32'(eu[k]));
            if (k == chg_at) src4[3] = chg_val;
            if (k == stall_idx) begin
                rdy4 = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    start4 = poke;
                    step;
                    start4 = 1'b0;
                    chk("stall_idx", 32'(idx4), 32'(k));
                    chk("stall_val", 32'(val4), 32'(ev[k]));
                    chk("stall_unk", 32'(unk4), 32'(eu[k]));
                    chk("stall_valid", 32'(valid4), 32'(1));
                end
                rdy4 = 1'b1;
            end
            step;
        end
        chk("done_hi", 32'(done4), 32'(1));
        chk("valid_lo", 32'(valid4), 32'(0));
        chk("busy_done", 32'(busy4), 32'(1));
        chk("tot_final", 32'(tot4), 32'(et));
        start4 = poke;
        step;
        start4 = 1'b0;
        chk("done_lo", 32'(done4), 32'(0));
        chk("busy_lo", 32'(busy4), 32'(0));
        chk("idle_valid", 32'(valid4), 32'(0));
        chk("tot_hold", 32'(tot4), 32'(et));
    endtask

    initial begin
        logic probe;
        int   n;
        probe = 1'bx;
        four_state = (probe === 1'bx);
        basic_src();
        for (int k = 0; k < 8; k++) src8[k] = 4'(k);

        #1;
        chk("rst_busy", 32'(busy4), 32'(0));
        chk("rst_valid", 32'(valid4), 32'(0));
        chk("rst_idx", 32'(idx4), 32'(0));
        chk("rst_val", 32'(val4), 32'(0));
        chk("rst_unk", 32'(unk4), 32'(0));
        chk("rst_done", 32'(done4), 32'(0));
        chk("rst_tot", 32'(tot4), 32'(0));
        step;
        step;
        rst = 1'b0;
        step;

        // plain scan, then backpressure with stray starts
        set_tot();
        chk("exp_tot_basic", 32'(et), 32'(four_state ? 10 : et));
        run4(-1, 0, 1'b0, -1, 4'b0000);
        run4(1, 3, 1'b1, -1, 4'b0000);

        // reset while idx2 is presented
        start4 = 1'b1;
        rdy4   = 1'b1;
        step;
        start4 = 1'b0;
        step;
        step;
        chk("pre_rst_idx", 32'(idx4), 32'(2));
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy4), 32'(0));
        chk("arst_valid", 32'(valid4), 32'(0));
        chk("arst_idx", 32'(idx4), 32'(0));
        chk("arst_val", 32'(val4), 32'(0));
        chk("arst_unk", 32'(unk4), 32'(0));
        chk("arst_tot", 32'(tot4), 32'(0));
        step;
        chk("arst_done", 32'(done4), 32'(0));
        rst = 1'b0;
        step;
        chk("post_rst_done", 32'(done4), 32'(0));
        run4(-1, 0, 1'b0, -1, 4'b0000);

        // src[3] changes while idx1 is presented
`ifdef TSR_SNAPSHOT_EN
        basic_src();
`else
        basic_src();
        expk(3, 4'b0000, 4'b0000, 4'b0000);
`endif
        set_tot();
        run4(-1, 0, 1'b0, 1, 4'b0000);

        basic_src();
        src4[3] = 4'b1100;
`ifdef TSR_SNAPSHOT_EN
        expk(3, 4'b1100, 4'b1100, 4'b0000);
`else
        expk(3, 4'b0011, 4'b0011, 4'b0000);
`endif
        set_tot();
        run4(-1, 0, 1'b0, 1, 4'b0011);

        // 8-element all-known scan, done in the 9th cycle after start
        start8 = 1'b1;
        rdy8   = 1'b1;
        step;
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 20) begin
            if (valid8) begin
                chk("e8_idx", 32'(idx8), 32'(n - 1));
                chk("e8_val", 32'(val8), 32'((n - 1) & 15));
                chk("e8_unk", 32'(unk8), 32'(0));
            end
            step;
            n++;
        end
        chk("e8_done_lat", 32'(n), 32'(9));
        chk("e8_tot", 32'(tot8), 32'(0));
        step;
        chk("e8_busy_lo", 32'(busy8), 32'(0));
        chk("e8_done_lo", 32'(done8), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
